// File: rtl/aes_round_ctrl.sv
// rtl/aes_round_ctrl.sv - iterative AES-128 encryption core, one round per clock.
// Optional AES_ROUND_CNT_EN adds the round_cnt output.

module aes_subbytes (
   input  logic [127:0] din,
   output logic [127:0] dout
);
   localparam logic [2047:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   function automatic logic [7:0] sbox_lookup(input logic [7:0] x);
      logic [10:0] base;
      base = 11'd2047 - {x, 3'b000};
      return SBOX[base -: 8];
   endfunction

   always_comb begin
      dout = '0;
      for (int i = 0; i < 16; i++)
         dout[127-8*i -: 8] = sbox_lookup(din[127-8*i -: 8]);
   end
endmodule

module aes_round_ctrl #(
   parameter int NR = 10
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in_data,
   input  logic [127:0] in_key,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_data,
   output logic         busy
`ifdef AES_ROUND_CNT_EN
   ,
   output logic [3:0]   round_cnt
`endif
);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t        state, state_nxt;
   logic [127:0]  state_reg, rk, nk;
   logic [127:0]  sb_out, sr_out, mc_out, rnd_out;
   logic [127:0]  ks_in, ks_out;
   logic [31:0]   ks_temp, w3;
   logic [3:0]    rnd;
   logic [7:0]    rcon;
   logic          last_rnd;
   logic          unused_ks;

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [127:0] shift_rows(input logic [127:0] s);
      logic [127:0] o;
      o = '0;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
      return o;
   endfunction

   function automatic logic [31:0] mix_col(input logic [31:0] w);
      logic [7:0] a0, a1, a2, a3;
      {a0, a1, a2, a3} = w;
      return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
              a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
              a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
              xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
   endfunction

   function automatic logic [7:0] rcon_of(input logic [3:0] r);
      case (r)
         4'd1:    return 8'h01;
         4'd2:    return 8'h02;
         4'd3:    return 8'h04;
         4'd4:    return 8'h08;
         4'd5:    return 8'h10;
         4'd6:    return 8'h20;
         4'd7:    return 8'h40;
         4'd8:    return 8'h80;
         4'd9:    return 8'h1b;
         4'd10:   return 8'h36;
         default: return 8'h00;
      endcase
   endfunction

   aes_subbytes u_sb_state (.din(state_reg), .dout(sb_out));
   aes_subbytes u_sb_key   (.din(ks_in),     .dout(ks_out));

   // Key schedule: SubWord(RotWord(w3)) from the upper lanes of the second S-box bank.
   assign w3        = rk[31:0];
   assign ks_in     = {w3[23:0], w3[31:24], 96'h0};
   assign unused_ks = ^ks_out[95:0];
   assign rcon      = rcon_of(rnd);
   assign ks_temp   = ks_out[127:96] ^ {rcon, 24'h0};
   assign nk[127:96] = rk[127:96] ^ ks_temp;
   assign nk[95:64]  = rk[95:64]  ^ nk[127:96];
   assign nk[63:32]  = rk[63:32]  ^ nk[95:64];
   assign nk[31:0]   = rk[31:0]   ^ nk[63:32];

   assign sr_out   = shift_rows(sb_out);
   assign mc_out   = {mix_col(sr_out[127:96]), mix_col(sr_out[95:64]),
                      mix_col(sr_out[63:32]),  mix_col(sr_out[31:0])};
   assign last_rnd = (rnd == 4'(NR));
   assign rnd_out  = (last_rnd ? sr_out : mc_out) ^ nk;
   assign out_data = state_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= '0;
         rk        <= '0;
         rnd       <= '0;
      end else begin
         case (state)
            IDLE: if (in_valid) begin
               state_reg <= in_data ^ in_key;
               rk        <= in_key;
               rnd       <= 4'd1;
            end
            RUN: begin
               state_reg <= rnd_out;
               rk        <= nk;
               rnd       <= rnd + 4'd1;
            end
            default: ;
         endcase
      end
   end

   // in_ready is gated by rst_n so no offer looks accepted while reset is held.
   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      case (state)
         IDLE: begin
            in_ready = rst_n;
            if (in_valid && rst_n) state_nxt = RUN;
         end
         RUN: begin
            busy = 1'b1;
            if (last_rnd) state_nxt = DONE;
         end
         DONE: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            if (out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

`ifdef AES_ROUND_CNT_EN
   always_comb begin
      round_cnt = 4'd0;
      if (state == RUN)       round_cnt = rnd;
      else if (state == DONE) round_cnt = 4'(NR);
   end
`endif
endmodule
